// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use hazard detection, bubble insertion
// and saturating stall/flush bubble counters.
module id_exe_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  IF_ID_rs,
  input  logic [REG_W-1:0]  IF_ID_rt,
  input  logic [REG_W-1:0]  IF_ID_rd,
  input  logic              IF_ID_use_rs,
  input  logic              IF_ID_use_rt,
  input  logic              ID_RegWr,
  input  logic              ID_MemRd,
  input  logic              ID_MemWr,
  input  logic              ID_ALUSrc,
  input  logic [2:0]        ID_ALUop,
  input  logic [DATA_W-1:0] ID_data1,
  input  logic [DATA_W-1:0] ID_data2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic              flush,
  input  logic              freeze,
  output logic [REG_W-1:0]  ID_EXE_rs,
  output logic [REG_W-1:0]  ID_EXE_rt,
  output logic [REG_W-1:0]  ID_EXE_rd,
  output logic              ID_EXE_RegWr,
  output logic              ID_EXE_MemRd,
  output logic              ID_EXE_MemWr,
  output logic              ID_EXE_ALUSrc,
  output logic [2:0]        ID_EXE_ALUop,
  output logic [DATA_W-1:0] ID_EXE_data1,
  output logic [DATA_W-1:0] ID_EXE_data2,
  output logic [DATA_W-1:0] ID_EXE_imm,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic rd_is_zero;
  logic rs_match;
  logic rt_match;
  logic load_use;

  // A load into a hardwired-zero r0 produces nothing worth waiting for.
  assign rd_is_zero = (R0_ZERO != 0) && (ID_EXE_rd == '0);
  assign rs_match   = IF_ID_use_rs && (ID_EXE_rd == IF_ID_rs);
  assign rt_match   = IF_ID_use_rt && (ID_EXE_rd == IF_ID_rt);
  assign load_use   = ID_EXE_MemRd && ID_EXE_RegWr && !rd_is_zero && (rs_match || rt_match);
  assign stall      = load_use && !flush && !freeze;

  // ID -> EXE register: freeze holds, flush/load-use insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EXE_rs     <= '0;
      ID_EXE_rt     <= '0;
      ID_EXE_rd     <= '0;
      ID_EXE_RegWr  <= 1'b0;
      ID_EXE_MemRd  <= 1'b0;
      ID_EXE_MemWr  <= 1'b0;
      ID_EXE_ALUSrc <= 1'b0;
      ID_EXE_ALUop  <= '0;
      ID_EXE_data1  <= '0;
      ID_EXE_data2  <= '0;
      ID_EXE_imm    <= '0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else if (!freeze) begin
      if (flush || load_use) begin
        ID_EXE_rs     <= '0;
        ID_EXE_rt     <= '0;
        ID_EXE_rd     <= '0;
        ID_EXE_RegWr  <= 1'b0;
        ID_EXE_MemRd  <= 1'b0;
        ID_EXE_MemWr  <= 1'b0;
        ID_EXE_ALUSrc <= 1'b0;
        ID_EXE_ALUop  <= '0;
        ID_EXE_data1  <= '0;
        ID_EXE_data2  <= '0;
        ID_EXE_imm    <= '0;
        if (flush) flush_cnt <= sat_inc(flush_cnt);
        else       stall_cnt <= sat_inc(stall_cnt);
      end else begin
        ID_EXE_rs     <= IF_ID_rs;
        ID_EXE_rt     <= IF_ID_rt;
        ID_EXE_rd     <= IF_ID_rd;
        ID_EXE_RegWr  <= ID_RegWr;
        ID_EXE_MemRd  <= ID_MemRd;
        ID_EXE_MemWr  <= ID_MemWr;
        ID_EXE_ALUSrc <= ID_ALUSrc;
        ID_EXE_ALUop  <= ID_ALUop;
        ID_EXE_data1  <= ID_data1;
        ID_EXE_data2  <= ID_data2;
        ID_EXE_imm    <= ID_imm;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: default instance plus an R0_ZERO=0,
// CNT_W=2 instance used for r0 hazards and counter saturation.
module tb_id_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  IF_ID_rs, IF_ID_rt, IF_ID_rd;
  logic        IF_ID_use_rs, IF_ID_use_rt;
  logic        ID_RegWr, ID_MemRd, ID_MemWr, ID_ALUSrc;
  logic [2:0]  ID_ALUop;
  logic [15:0] ID_data1, ID_data2, ID_imm;
  logic        flush, freeze;

  logic [2:0]  ID_EXE_rs, ID_EXE_rt, ID_EXE_rd;
  logic        ID_EXE_RegWr, ID_EXE_MemRd, ID_EXE_MemWr, ID_EXE_ALUSrc;
  logic [2:0]  ID_EXE_ALUop;
  logic [15:0] ID_EXE_data1, ID_EXE_data2, ID_EXE_imm;
  logic        stall;
  logic [15:0] stall_cnt, flush_cnt;

  logic [2:0]  d2_rs, d2_rt, d2_rd;
  logic        d2_RegWr, d2_MemRd, d2_MemWr, d2_ALUSrc;
  logic [2:0]  d2_ALUop;
  logic [15:0] d2_data1, d2_data2, d2_imm;
  logic        d2_stall;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_stage dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_rd(IF_ID_rd),
    .IF_ID_use_rs(IF_ID_use_rs), .IF_ID_use_rt(IF_ID_use_rt),
    .ID_RegWr(ID_RegWr), .ID_MemRd(ID_MemRd), .ID_MemWr(ID_MemWr), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUop(ID_ALUop), .ID_data1(ID_data1), .ID_data2(ID_data2), .ID_imm(ID_imm),
    .flush(flush), .freeze(freeze),
    .ID_EXE_rs(ID_EXE_rs), .ID_EXE_rt(ID_EXE_rt), .ID_EXE_rd(ID_EXE_rd),
    .ID_EXE_RegWr(ID_EXE_RegWr), .ID_EXE_MemRd(ID_EXE_MemRd), .ID_EXE_MemWr(ID_EXE_MemWr),
    .ID_EXE_ALUSrc(ID_EXE_ALUSrc), .ID_EXE_ALUop(ID_EXE_ALUop),
    .ID_EXE_data1(ID_EXE_data1), .ID_EXE_data2(ID_EXE_data2), .ID_EXE_imm(ID_EXE_imm),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_stage #(.R0_ZERO(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_rd(IF_ID_rd),
    .IF_ID_use_rs(IF_ID_use_rs), .IF_ID_use_rt(IF_ID_use_rt),
    .ID_RegWr(ID_RegWr), .ID_MemRd(ID_MemRd), .ID_MemWr(ID_MemWr), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUop(ID_ALUop), .ID_data1(ID_data1), .ID_data2(ID_data2), .ID_imm(ID_imm),
    .flush(flush), .freeze(freeze),
    .ID_EXE_rs(d2_rs), .ID_EXE_rt(d2_rt), .ID_EXE_rd(d2_rd),
    .ID_EXE_RegWr(d2_RegWr), .ID_EXE_MemRd(d2_MemRd), .ID_EXE_MemWr(d2_MemWr),
    .ID_EXE_ALUSrc(d2_ALUSrc), .ID_EXE_ALUop(d2_ALUop),
    .ID_EXE_data1(d2_data1), .ID_EXE_data2(d2_data2), .ID_EXE_imm(d2_imm),
    .stall(d2_stall), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic regwr, input logic memrd, input logic [2:0] rd,
                        input logic [2:0] rs, input logic use_rs,
                        input logic [2:0] rt, input logic use_rt,
                        input logic [15:0] d1);
    ID_RegWr = regwr; ID_MemRd = memrd; IF_ID_rd = rd;
    IF_ID_rs = rs; IF_ID_use_rs = use_rs;
    IF_ID_rt = rt; IF_ID_use_rt = use_rt;
    ID_data1 = d1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    ID_MemWr = 1'b0; ID_ALUSrc = 1'b0; ID_ALUop = 3'd0;
    ID_data2 = 16'h0; ID_imm = 16'h0;
    set_id(1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0, 16'hFFFF);
    repeat (2) step();
    chk("rst_regwr", {31'd0, ID_EXE_RegWr}, 32'd0);
    chk("rst_rd", {29'd0, ID_EXE_rd}, 32'd0);
    chk("rst_data1", {16'd0, ID_EXE_data1}, 32'd0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // 1: plain capture
    set_id(1'b1, 1'b0, 3'd3, 3'd1, 1'b1, 3'd4, 1'b1, 16'h1234);
    ID_data2 = 16'h5678; ID_imm = 16'h0042; ID_ALUop = 3'd5; ID_ALUSrc = 1'b1;
    #1 chk("t1_stall_pre", {31'd0, stall}, 32'd0);
    step();
    chk("t1_regwr", {31'd0, ID_EXE_RegWr}, 32'd1);
    chk("t1_rd", {29'd0, ID_EXE_rd}, 32'd3);
    chk("t1_rs_rt", {26'd0, ID_EXE_rs, ID_EXE_rt}, {26'd0, 3'd1, 3'd4});
    chk("t1_data1", {16'd0, ID_EXE_data1}, 32'h1234);
    chk("t1_data2_imm", {ID_EXE_data2, ID_EXE_imm}, 32'h5678_0042);
    chk("t1_alu", {28'd0, ID_EXE_ALUSrc, ID_EXE_ALUop}, {28'd0, 1'b1, 3'd5});
    chk("t1_stall", {31'd0, stall}, 32'd0);
    ID_data2 = 16'h0; ID_imm = 16'h0; ID_ALUop = 3'd0; ID_ALUSrc = 1'b0;

    // 2: load-use stall on rs
    set_id(1'b1, 1'b1, 3'd2, 3'd1, 1'b1, 3'd0, 1'b0, 16'h0000);
    step();
    set_id(1'b1, 1'b0, 3'd5, 3'd2, 1'b1, 3'd6, 1'b1, 16'hAAAA);
    #1 chk("t2_stall", {30'd0, stall, d2_stall}, 32'd3);
    step();
    chk("t2_bubble_ctl", {28'd0, ID_EXE_RegWr, ID_EXE_MemRd, ID_EXE_MemWr, ID_EXE_ALUSrc}, 32'd0);
    chk("t2_bubble_regs", {23'd0, ID_EXE_rs, ID_EXE_rt, ID_EXE_rd}, 32'd0);
    chk("t2_bubble_data", {16'd0, ID_EXE_data1}, 32'd0);
    chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("t2_stall_drop", {31'd0, stall}, 32'd0);
    step();
    chk("t2_adv_rs", {29'd0, ID_EXE_rs}, 32'd2);
    chk("t2_adv_rd", {29'd0, ID_EXE_rd}, 32'd5);
    chk("t2_adv_data1", {16'd0, ID_EXE_data1}, 32'hAAAA);
    chk("t2_stall_cnt_hold", {16'd0, stall_cnt}, 32'd1);

    // 3: load to r0 with a reader of r0
    set_id(1'b1, 1'b1, 3'd0, 3'd7, 1'b1, 3'd0, 1'b0, 16'h0000);
    step();
    set_id(1'b1, 1'b0, 3'd4, 3'd0, 1'b1, 3'd0, 1'b0, 16'h0BEE);
    #1 chk("t3_stall_r0", {31'd0, stall}, 32'd0);
    chk("t3_stall_nor0", {31'd0, d2_stall}, 32'd1);
    step();
    chk("t3_capture", {28'd0, ID_EXE_RegWr, ID_EXE_rd}, {28'd0, 1'b1, 3'd4});
    chk("t3_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("t3_d2_bubble", {28'd0, d2_RegWr, d2_rd}, 32'd0);
    chk("t3_d2_cnt", {30'd0, d2_stall_cnt}, 32'd2);
    step();

    // 4: flush beats load-use
    set_id(1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000);
    step();
    set_id(1'b1, 1'b0, 3'd1, 3'd2, 1'b1, 3'd0, 1'b0, 16'h1111);
    flush = 1'b1;
    #1 chk("t4_stall", {30'd0, stall, d2_stall}, 32'd0);
    step();
    flush = 1'b0;
    chk("t4_bubble", {28'd0, ID_EXE_RegWr, ID_EXE_rd}, 32'd0);
    chk("t4_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("t4_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("t4_d2_cnts", {28'd0, d2_stall_cnt, d2_flush_cnt}, {28'd0, 2'd2, 2'd1});

    // 5: freeze holds everything and masks flush
    set_id(1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0F0F);
    step();
    chk("t5_pre_rd", {29'd0, ID_EXE_rd}, 32'd6);
    freeze = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b0, 1'b1, 3'(i + 1), 3'(i), 1'b1, 3'd0, 1'b0, 16'(16'h5000 + i));
      step();
      chk("t5_hold_rd", {29'd0, ID_EXE_rd}, 32'd6);
      chk("t5_hold_data", {ID_EXE_data1, 15'd0, ID_EXE_RegWr}, {16'h0F0F, 16'd1});
      chk("t5_hold_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
    end
    freeze = 1'b0;
    step();
    flush = 1'b0;
    chk("t5_release_bubble", {28'd0, ID_EXE_RegWr, ID_EXE_rd}, 32'd0);
    chk("t5_release_flush_cnt", {16'd0, flush_cnt}, 32'd2);

    // 6: repeated self-dependent loads, saturation, async reset
    set_id(1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0, 16'h7777);
    step();
    chk("t6_first_stall", {31'd0, stall}, 32'd1);
    repeat (7) step();
    chk("t6_cnt_16", {16'd0, stall_cnt}, 32'd5);
    chk("t6_cnt_sat", {30'd0, d2_stall_cnt}, 32'd3);
    repeat (2) step();
    chk("t6_cnt_sat_hold", {30'd0, d2_stall_cnt}, 32'd3);
    step();
    chk("t6_load_held", {30'd0, ID_EXE_MemRd, stall}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_ctl", {28'd0, ID_EXE_RegWr, ID_EXE_MemRd, ID_EXE_MemWr, ID_EXE_ALUSrc}, 32'd0);
    chk("t6_arst_regs", {23'd0, ID_EXE_rs, ID_EXE_rt, ID_EXE_rd}, 32'd0);
    chk("t6_arst_data", {16'd0, ID_EXE_data1}, 32'd0);
    chk("t6_arst_cnts", {stall_cnt, flush_cnt}, 32'd0);
    chk("t6_arst_stall", {31'd0, stall}, 32'd0);
    chk("t6_arst_d2", {29'd0, d2_stall, d2_stall_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
